// File: rtl/ks_pkg.sv
// Shared constants, FSM state encoding and slice-selection helper for the
// sequential wide KoggeStone adder.
package ks_pkg;
  localparam int SLICE_W    = 16;
  localparam int MAX_NWORDS = 16;
  localparam int MAX_W      = SLICE_W * MAX_NWORDS;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Operands are zero-extended to MAX_W so one helper serves every NWORDS.
  function automatic logic [SLICE_W-1:0] slice_sel(input logic [MAX_W-1:0] word,
                                                   input logic [3:0]       idx);
    logic [7:0] base;
    base = {idx, 4'b0000};
    return word[base +: SLICE_W];
  endfunction
endpackage

// File: rtl/KoggeStone.sv
// 16-bit Kogge-Stone parallel-prefix adder; carry-in is folded in as an
// extra prefix position below bit 0.
module KoggeStone (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [16:0] gk, pk, gn, pn;

  always_comb begin
    gk = {A & B, Cin};
    pk = {A ^ B, 1'b0};
    gn = gk;
    pn = pk;
    for (int l = 0; l < 5; l++) begin
      gn = gk;
      pn = pk;
      for (int j = 0; j < 17; j++) begin
        if (j >= (1 << l)) begin
          gn[j] = gk[j] | (pk[j] & gk[j - (1 << l)]);
          pn[j] = pk[j] & pk[j - (1 << l)];
        end
      end
      gk = gn;
      pk = pn;
    end
  end

  // gk[i] is the carry into bit i after the prefix tree collapses.
  assign S    = (A ^ B) ^ gk[15:0];
  assign Cout = gk[16];
endmodule

// File: rtl/ks_wide_add_seq.sv
// Streams NWORDS x 16-bit operands through one KoggeStone slice, LSW first,
// registering the inter-slice carry and assembling the wide result.
module ks_wide_add_seq
  import ks_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE_W*NWORDS-1:0] in_a,
  input  logic [SLICE_W*NWORDS-1:0] in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLICE_W*NWORDS-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_ovf
);
  localparam int W    = SLICE_W * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t                         state_reg;
  logic [IDXW-1:0]                idx_reg;
  logic                           carry_reg;
  logic [W-1:0]                   a_reg, b_reg;
  logic                           sub_reg;
  logic [NWORDS-1:0][SLICE_W-1:0] sum_reg;
  logic                           cout_reg, ovf_reg, valid_reg;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_cout, last_slice, a_top, b_top, ovf_next;

  assign slice_a = slice_sel(MAX_W'(a_reg), 4'(idx_reg));
  assign slice_b = slice_sel(MAX_W'(b_reg), 4'(idx_reg)) ^ {SLICE_W{sub_reg}};

  KoggeStone u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_reg),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  assign last_slice = (idx_reg == IDXW'(NWORDS - 1));
  assign a_top      = a_reg[W-1];
  assign b_top      = b_reg[W-1] ^ sub_reg;
  // Only meaningful on the top slice, where slice_s[15] is the result sign.
  assign ovf_next   = (a_top ~^ b_top) & (slice_s[SLICE_W-1] ^ a_top);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            sub_reg   <= in_sub;
            idx_reg   <= '0;
            carry_reg <= in_sub;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx_reg] <= slice_s;
          carry_reg        <= slice_cout;
          if (last_slice) begin
            idx_reg   <= '0;
            cout_reg  <= slice_cout;
            ovf_reg   <= ovf_next;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_sum
      assign out_sum[gi*SLICE_W +: SLICE_W] = sum_reg[gi];
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = valid_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;
endmodule

// File: doc/ks_wide_add_seq.md
Name: ks_wide_add_seq

Overview:
- Sequential operand feeder for the existing 16-bit KoggeStone adder.
- Accepts wide operands (NWORDS x 16 bits) over a valid/ready handshake and streams them through one KoggeStone slice, 16 bits per cycle, LSW first.
- Registers the inter-slice carry and assembles the wide sum, carry-out and signed overflow flag; supports add and subtract.
- Sits upstream of the adder (drives its A, B, Cin) and downstream of any wide-datapath producer.

Parameters:
- NWORDS, 4, number of 16-bit slices per operand; legal range 1..16; operand width W = 16*NWORDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (combinational: state==IDLE).
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  result valid (registered).
- out_ready  input  1  consumer takes result.
- out_sum  output  W  result.
- out_cout  output  1  final carry; for subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset is sampled on the clock edge only, and any asserted rst wins over all other inputs.
  - Reset state: IDLE, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, idx=0, carry=0.
  - in_ready is therefore 1 in the first cycle after reset.
- The FSM has three states, IDLE, RUN and DONE:
  - IDLE: in_ready=1.
    - On in_valid&in_ready, latch in_a, in_b and in_sub.
    - Set idx=0 and carry=in_sub, then go to RUN.
  - RUN, one slice per cycle:
    - KoggeStone A = a[idx*16 +: 16].
    - KoggeStone B = b[idx*16 +: 16] XOR {16{sub}}.
    - KoggeStone Cin = carry.
    - At each edge: out_sum[idx*16 +: 16] <= S, carry <= Cout, idx <= idx+1.
    - On the edge where idx==NWORDS-1: out_cout <= Cout, out_ovf computed, go to DONE with out_valid <= 1.
  - DONE: out_valid=1 and out_sum/out_cout/out_ovf are held stable.
    - On out_ready go to IDLE with out_valid <= 0.
- Latency: out_valid rises exactly NWORDS edges after the accepting edge.
  - Throughput: one op per NWORDS+2 cycles, with out_ready held high.
- Overflow uses the top slice MSBs: aM = a[W-1], bM = effective (inverted if sub) b[W-1], sM = S[15].
  - out_ovf = (aM ~^ bM) & (sM ^ aM).
- While out_valid is low, out_sum holds partial or previous data and is undefined to the consumer.
- Boundary conditions:
  - in_valid outside IDLE is ignored; operands do not change mid-operation because they were latched.
  - NWORDS=1: single RUN cycle; out_valid one edge after acceptance.
  - DONE with out_ready=0: all outputs held indefinitely, in_ready=0.
  - out_ready asserted while not in DONE has no effect.
  - rst mid-RUN or in DONE: operation abandoned, no out_valid pulse, outputs to reset values.
  - idx wraps to 0 on entry to DONE.
  - Carry ripples across slices only through the carry register; no combinational path between slices.

Decomposition:
- Package ks_pkg holds:
  - SLICE_W = 16.
  - The state typedef (IDLE, RUN, DONE).
  - The helper function slice_sel(word, idx).
- Exactly one sub-module: one instance of the existing KoggeStone (ports A, B, Cin, S, Cout), 16-bit.
- Everything else is in this module: FSM, index counter, carry register, result assembly.

Test Plan:
1. NWORDS=4, in_a=0x0000_0000_0000_1111, in_b=0x0000_0000_0000_ABCD, sub=0 -> out_sum=0x0000_0000_0000_BCDE, cout=0, ovf=0; out_valid exactly 4 edges after acceptance.
2. in_a=0xFFFF_FFFF_FFFF_FFFF, in_b=0x1, sub=0 -> carry ripples through all slices: out_sum=0, cout=1, ovf=0.
3. in_a=0x7FFF_FFFF_FFFF_FFFF, in_b=0x1, sub=0 -> out_sum=0x8000_0000_0000_0000, cout=0, ovf=1.
4. Subtraction:
   - a=7, b=5, sub=1 -> sum=0x2, cout=1, ovf=0.
   - then a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
   - then a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with new operands throughout.
   - Required: out_sum/out_cout/out_ovf stable, in_ready=0, new operands ignored.
   - Then out_ready=1 for one cycle -> IDLE, in_ready=1; the next op gives the correct result.
6. Assert rst for one cycle after 2 RUN edges.
   - Required: next cycle out_valid=0, out_sum=0, in_ready=1, no spurious out_valid.
   - A subsequent op (a=0x1111, b=0xABCD) completes as in case 1; repeat with NWORDS=1.
